// File: rtl/genius_game_ctrl_if.sv
// Player/ROM/lamp signal bundle for the Genius game sequencer.
// The controller takes the slave modport; the surrounding system takes the master.
interface genius_game_ctrl_if #(
  parameter int unsigned SIZE = 4
);
  logic            start;
  logic [SIZE-1:0] level;
  logic            btn_valid;
  logic [1:0]      btn_color;
  logic [1:0]      seq_color;
  logic [SIZE-1:0] seq_addr;
  logic            led_on;
  logic [1:0]      led_color;
  logic [SIZE-1:0] round;
  logic            expect_in;
  logic            busy;
  logic            win;
  logic            lose;

  modport master (
    output start, level, btn_valid, btn_color, seq_color,
    input  seq_addr, led_on, led_color, round, expect_in, busy, win, lose
  );

  modport slave (
    input  start, level, btn_valid, btn_color, seq_color,
    output seq_addr, led_on, led_color, round, expect_in, busy, win, lose
  );
endinterface

// File: rtl/genius_game_ctrl.sv
// Genius (Simon) sequencer: replays the colour sequence of the current round,
// then checks player presses against it, ending in a sticky win or lose.
module genius_game_ctrl #(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned ON_TICKS  = 8,
  parameter int unsigned OFF_TICKS = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned TMR_W     = 8
) (
  input logic               clk,
  input logic               R,
  genius_game_ctrl_if.slave bus
);

  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_TICKS - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_TICKS - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, PAUSE, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE
  } state_t;

  state_t            state, state_n;
  logic [SIZE-1:0]   round_q, round_n;
  logic [SIZE-1:0]   idx, idx_n;
  logic [SIZE-1:0]   level_q, level_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic              led_on, expect_in, busy, win, lose;

  // Next-state, counters and timer
  always_comb begin
    state_n = state;
    round_n = round_q;
    idx_n   = idx;
    level_n = level_q;
    timer_n = timer;
    case (state)
      IDLE, WIN, LOSE: begin
        if (bus.start) begin
          state_n = PAUSE;
          round_n = '0;
          idx_n   = '0;
          timer_n = '0;
          level_n = bus.level;
        end
      end
      PAUSE: begin
        if (timer == OFF_LAST) begin
          timer_n = '0;
          idx_n   = '0;
          state_n = SHOW_ON;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      SHOW_ON: begin
        if (timer == ON_LAST) begin
          timer_n = '0;
          state_n = SHOW_OFF;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      SHOW_OFF: begin
        if (timer == OFF_LAST) begin
          timer_n = '0;
          if (idx == round_q) begin
            idx_n   = '0;
            state_n = WAIT_IN;
          end else begin
            idx_n   = idx + SIZE'(1);
            state_n = SHOW_ON;
          end
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      WAIT_IN: begin
        // A press on the final timeout cycle is evaluated ahead of the timeout
        if (bus.btn_valid) begin
          timer_n = '0;
          if (bus.btn_color != bus.seq_color) begin
            state_n = LOSE;
          end else if (idx != round_q) begin
            idx_n = idx + SIZE'(1);
          end else if (round_q == level_q) begin
            state_n = WIN;
          end else begin
            round_n = round_q + SIZE'(1);
            idx_n   = '0;
            state_n = PAUSE;
          end
        end else if (timer == TO_LAST) begin
          timer_n = '0;
          state_n = LOSE;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (R) begin
      state     <= IDLE;
      round_q   <= '0;
      idx       <= '0;
      level_q   <= '0;
      timer     <= '0;
      led_on    <= 1'b0;
      expect_in <= 1'b0;
      busy      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      state     <= state_n;
      round_q   <= round_n;
      idx       <= idx_n;
      level_q   <= level_n;
      timer     <= timer_n;
      led_on    <= (state_n == SHOW_ON);
      expect_in <= (state_n == WAIT_IN);
      busy      <= !(state_n inside {IDLE, WIN, LOSE});
      win       <= (state_n == WIN);
      lose      <= (state_n == LOSE);
    end
  end

  assign bus.seq_addr  = idx;
  assign bus.round     = round_q;
  assign bus.led_on    = led_on;
  assign bus.expect_in = expect_in;
  assign bus.busy      = busy;
  assign bus.win       = win;
  assign bus.lose      = lose;
  assign bus.led_color = led_on ? bus.seq_color : 2'b00;

endmodule

// File: tb/tb_genius_game_ctrl.sv
// Directed bench for genius_game_ctrl: vector table for whole games plus
// hand-written sequences for timeout, ignored inputs and mid-game reset.
module tb_genius_game_ctrl;
  localparam int unsigned SIZE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  genius_game_ctrl_if #(.SIZE(SIZE)) bus ();

  genius_game_ctrl #(
    .SIZE(SIZE), .ON_TICKS(2), .OFF_TICKS(1), .TIMEOUT(5), .TMR_W(8)
  ) dut (
    .clk (clk),
    .R   (rst),
    .bus (bus.slave)
  );

  logic [1:0] rom [4];
  initial begin
    rom[0] = 2'd2; rom[1] = 2'd0; rom[2] = 2'd3; rom[3] = 2'd1;
  end
  assign bus.seq_color = rom[bus.seq_addr[1:0]];

  typedef struct packed {
    logic       led_on;
    logic [1:0] led_color;
    logic [3:0] round;
    logic       expect_in;
    logic       busy;
    logic       win;
    logic       lose;
    logic [3:0] addr;
  } out_t;

  typedef struct {
    logic       start;
    logic [3:0] level;
    logic       bv;
    logic [1:0] bc;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic out_t o(input logic l, input logic [1:0] c, input logic [3:0] r,
                             input logic e, input logic b, input logic w,
                             input logic ls, input logic [3:0] a);
    out_t t;
    t.led_on = l; t.led_color = c; t.round = r; t.expect_in = e;
    t.busy = b; t.win = w; t.lose = ls; t.addr = a;
    return t;
  endfunction

  function automatic void add(input logic s, input logic [3:0] lv, input logic bv,
                              input logic [1:0] bc, input out_t e);
    vec_t v;
    v.start = s; v.level = lv; v.bv = bv; v.bc = bc; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t got;
    got.led_on = bus.led_on; got.led_color = bus.led_color; got.round = bus.round;
    got.expect_in = bus.expect_in; got.busy = bus.busy; got.win = bus.win;
    got.lose = bus.lose; got.addr = bus.seq_addr;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got led=%b col=%0d rnd=%0d exp_in=%b busy=%b win=%b lose=%b addr=%0d want led=%b col=%0d rnd=%0d exp_in=%b busy=%b win=%b lose=%b addr=%0d",
               name, got.led_on, got.led_color, got.round, got.expect_in, got.busy,
               got.win, got.lose, got.addr, exp.led_on, exp.led_color, exp.round,
               exp.expect_in, exp.busy, exp.win, exp.lose, exp.addr);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [3:0] lv,
                      input logic bv, input logic [1:0] bc);
    @(negedge clk);
    rst = r; bus.start = s; bus.level = lv; bus.btn_valid = bv; bus.btn_color = bc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 1'b0, 2'd0);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.level = '0; bus.btn_valid = 1'b0; bus.btn_color = '0;

    // level 0: one colour, then win
    add(1, 0, 0, 0, o(0, 0, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(1, 2, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(1, 2, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(0, 0, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(0, 0, 0, 1, 1, 0, 0, 0));
    add(0, 0, 1, 2, o(0, 0, 0, 0, 0, 1, 0, 0));
    // level 1: two rounds, win
    add(1, 1, 0, 0, o(0, 0, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(1, 2, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(1, 2, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(0, 0, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(0, 0, 0, 1, 1, 0, 0, 0));
    add(0, 0, 1, 2, o(0, 0, 1, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(1, 2, 1, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(1, 2, 1, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(0, 0, 1, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(1, 0, 1, 0, 1, 0, 0, 1));
    add(0, 0, 0, 0, o(1, 0, 1, 0, 1, 0, 0, 1));
    add(0, 0, 0, 0, o(0, 0, 1, 0, 1, 0, 0, 1));
    add(0, 0, 0, 0, o(0, 0, 1, 1, 1, 0, 0, 0));
    add(0, 0, 1, 2, o(0, 0, 1, 1, 1, 0, 0, 1));
    add(0, 0, 1, 0, o(0, 0, 1, 0, 0, 1, 0, 1));
    // level 2: wrong colour in round 1
    add(1, 2, 0, 0, o(0, 0, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(1, 2, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(1, 2, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(0, 0, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(0, 0, 0, 1, 1, 0, 0, 0));
    add(0, 0, 1, 2, o(0, 0, 1, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(1, 2, 1, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(1, 2, 1, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(0, 0, 1, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, o(1, 0, 1, 0, 1, 0, 0, 1));
    add(0, 0, 0, 0, o(1, 0, 1, 0, 1, 0, 0, 1));
    add(0, 0, 0, 0, o(0, 0, 1, 0, 1, 0, 0, 1));
    add(0, 0, 0, 0, o(0, 0, 1, 1, 1, 0, 0, 0));
    add(0, 0, 1, 2, o(0, 0, 1, 1, 1, 0, 0, 1));
    add(0, 0, 1, 3, o(0, 0, 1, 0, 0, 0, 1, 1));

    step(1'b1, 1'b0, 4'd0, 1'b0, 2'd0);
    check("reset", o(0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].start, vecs[i].level, vecs[i].bv, vecs[i].bc);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Timeout: five idle cycles in WAIT_IN lose
    step(1'b0, 1'b1, 4'd0, 1'b0, 2'd0);
    check("restart_from_lose", o(0, 0, 0, 0, 1, 0, 0, 0));
    repeat (3) idle();
    idle();
    check("enter_wait", o(0, 0, 0, 1, 1, 0, 0, 0));
    repeat (4) idle();
    check("wait_5th_cycle", o(0, 0, 0, 1, 1, 0, 0, 0));
    idle();
    check("timeout_lose", o(0, 0, 0, 0, 0, 0, 1, 0));

    // Press on the fifth WAIT_IN cycle is still accepted
    step(1'b0, 1'b1, 4'd0, 1'b0, 2'd0);
    repeat (4) idle();
    repeat (4) idle();
    step(1'b0, 1'b0, 4'd0, 1'b1, 2'd2);
    check("press_on_5th", o(0, 0, 0, 0, 0, 1, 0, 0));

    // Presses and start during replay are ignored; level held from start
    step(1'b0, 1'b1, 4'd1, 1'b0, 2'd0);
    idle();
    check("show_on_1", o(1, 2, 0, 0, 1, 0, 0, 0));
    step(1'b0, 1'b1, 4'd0, 1'b1, 2'd3);
    check("ignored_pulses", o(1, 2, 0, 0, 1, 0, 0, 0));
    idle();
    idle();
    check("wait_after_ignored", o(0, 0, 0, 1, 1, 0, 0, 0));
    step(1'b0, 1'b0, 4'd0, 1'b1, 2'd2);
    check("level_held", o(0, 0, 1, 0, 1, 0, 0, 0));
    idle();
    check("show_on_r1", o(1, 2, 1, 0, 1, 0, 0, 0));

    // Reset mid SHOW_ON
    step(1'b1, 1'b0, 4'd0, 1'b0, 2'd0);
    check("reset_mid_show", o(0, 0, 0, 0, 0, 0, 0, 0));
    idle();
    check("idle_after_reset", o(0, 0, 0, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
